// File: rtl/wb_uart_lite_pkg.sv
// Shared definitions for the lite Wishbone UART:
// register offsets, STATUS/IER bit positions, FSM states.
package wb_uart_lite_pkg;

    localparam logic [2:0] ADR_DATA   = 3'd0;
    localparam logic [2:0] ADR_STATUS = 3'd1;
    localparam logic [2:0] ADR_DIV_LO = 3'd2;
    localparam logic [2:0] ADR_DIV_HI = 3'd3;
    localparam logic [2:0] ADR_IER    = 3'd4;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_TX_IDLE  = 3;
    localparam int ST_RX_OVR   = 4;
    localparam int ST_RX_FERR  = 5;

    localparam int IER_RX = 0;
    localparam int IER_TX = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_e;

    // Divisors below 2 would make the mid-bit sample point degenerate.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/wb_uart_lite_fifo.sv
// Single-clock TX FIFO, first-word-fall-through read port.
// A push while full is dropped, even if a pop happens the same cycle.
module wb_uart_lite_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart_lite.sv
// Lite UART with an 8-bit classic Wishbone slave port,
// TX FIFO, single-byte RX holding register and level interrupt.
module wb_uart_lite
    import wb_uart_lite_pkg::*;
#(
    parameter int          TX_FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET     = 16'd15
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic [2:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_we_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic [2:0] wb_cti_i,
    input  logic [1:0] wb_bte_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       wb_err_o,
    output logic       wb_rty_o,
    output logic       tx_o,
    input  logic       rx_i,
    output logic       int_o
);

    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

    logic          acc;
    logic          wr;
    logic          rd;
    logic [7:0]    rdata;
    logic [7:0]    status;
    logic [7:0]    div_lo;
    logic [7:0]    div_hi;
    logic [15:0]   div_eff;
    logic [1:0]    ier;
    logic [7:0]    rx_hold;
    logic          rx_valid;
    logic          rx_ovr;
    logic          rx_ferr;
    logic          rx_done;
    logic          rx_bad;
    logic          tx_push;
    logic          tx_pop;
    logic [7:0]    fifo_rdata;
    logic          tx_full;
    logic          tx_empty;
    logic          tx_idle;
    logic [CW-1:0] fifo_cnt_unused;
    logic          bus_unused;

    uart_state_e tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;

    uart_state_e rx_state;
    logic [15:0] rx_cnt;
    logic [15:0] rx_div;
    logic [15:0] rx_half;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;
    logic        rx_m;
    logic        rx_s;
    logic        rx_q;

    assign wb_err_o   = 1'b0;
    assign wb_rty_o   = 1'b0;
    assign bus_unused = ^{wb_cti_i, wb_bte_i};

    assign acc     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr      = acc & wb_we_i;
    assign rd      = acc & ~wb_we_i;
    assign div_eff = eff_div({div_hi, div_lo});
    assign tx_push = wr && (wb_adr_i == ADR_DATA);
    assign tx_idle = tx_empty && (tx_state == S_IDLE);
    assign tx_pop  = !tx_empty
                     && ((tx_state == S_IDLE)
                     || (tx_state == S_STOP && tx_cnt == 16'd0));
    assign rx_half = (rx_div >> 1) + {15'd0, rx_div[0]};

    wb_uart_lite_fifo #(
        .DEPTH (TX_FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .push  (tx_push),
        .wdata (wb_dat_i),
        .pop   (tx_pop),
        .rdata (fifo_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .count (fifo_cnt_unused)
    );

    always_comb begin
        status              = 8'h00;
        status[ST_RX_VALID] = rx_valid;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_IDLE]  = tx_idle;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_RX_FERR]  = rx_ferr;
    end

    always_comb begin
        rdata = 8'h00;
        case (wb_adr_i)
            ADR_DATA:   rdata = rx_valid ? rx_hold : 8'h00;
            ADR_STATUS: rdata = status;
            ADR_DIV_LO: rdata = div_lo;
            ADR_DIV_HI: rdata = div_hi;
            ADR_IER:    rdata = {6'd0, ier};
            default:    rdata = 8'h00;
        endcase
    end

    // Bus side effects and RX arrivals share one block so a
    // completion racing a DATA read resolves in a single place.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 8'h00;
            div_lo   <= DIV_RESET[7:0];
            div_hi   <= DIV_RESET[15:8];
            ier      <= 2'b00;
            rx_hold  <= 8'h00;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            rx_ferr  <= 1'b0;
            int_o    <= 1'b0;
        end else begin
            wb_ack_o <= acc;
            wb_dat_o <= rd ? rdata : 8'h00;
            if (wr) begin
                case (wb_adr_i)
                    ADR_DIV_LO: div_lo <= wb_dat_i;
                    ADR_DIV_HI: div_hi <= wb_dat_i;
                    ADR_IER:    ier    <= wb_dat_i[1:0];
                    default:    ;
                endcase
            end
            if (rd && wb_adr_i == ADR_STATUS) begin
                rx_ovr  <= 1'b0;
                rx_ferr <= 1'b0;
            end
            if (rd && wb_adr_i == ADR_DATA) begin
                rx_valid <= 1'b0;
            end
            if (rx_done) begin
                if (rx_valid && !(rd && wb_adr_i == ADR_DATA)) begin
                    rx_ovr <= 1'b1;
                end else begin
                    rx_hold  <= rx_sh;
                    rx_valid <= 1'b1;
                end
            end
            if (rx_bad) begin
                rx_ferr <= 1'b1;
            end
            int_o <= (ier[IER_RX] & rx_valid) | (ier[IER_TX] & tx_empty);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tx_state <= S_IDLE;
            tx_o     <= 1'b1;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_sh    <= 8'h00;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (!tx_empty) begin
                        tx_state <= S_START;
                        tx_o     <= 1'b0;
                        tx_sh    <= fifo_rdata;
                        tx_cnt   <= div_eff;
                    end
                end
                S_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_state <= S_DATA;
                        tx_o     <= tx_sh[0];
                        tx_bit   <= 3'd0;
                        tx_cnt   <= div_eff;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= div_eff;
                        if (tx_bit == 3'd7) begin
                            tx_state <= S_STOP;
                            tx_o     <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                            tx_o   <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt == 16'd0) begin
                        if (!tx_empty) begin
                            tx_state <= S_START;
                            tx_o     <= 1'b0;
                            tx_sh    <= fifo_rdata;
                            tx_cnt   <= div_eff;
                        end else begin
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // Counts up from the start edge; samples mid-bit and leaves STOP
    // at its sample point so a following start edge is not missed.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_state <= S_IDLE;
            rx_cnt   <= 16'd0;
            rx_div   <= 16'd2;
            rx_bit   <= 3'd0;
            rx_sh    <= 8'h00;
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            rx_q     <= 1'b1;
            rx_done  <= 1'b0;
            rx_bad   <= 1'b0;
        end else begin
            rx_m    <= rx_i;
            rx_s    <= rx_m;
            rx_q    <= rx_s;
            rx_done <= 1'b0;
            rx_bad  <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_q && !rx_s) begin
                        rx_state <= S_START;
                        rx_cnt   <= 16'd0;
                        rx_div   <= div_eff;
                    end
                end
                S_START: begin
                    if (rx_cnt == rx_half && rx_s) begin
                        rx_state <= S_IDLE;
                    end else if (rx_cnt == rx_div) begin
                        rx_state <= S_DATA;
                        rx_cnt   <= 16'd0;
                        rx_bit   <= 3'd0;
                        rx_div   <= div_eff;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == rx_half) begin
                        rx_sh <= {rx_s, rx_sh[7:1]};
                    end
                    if (rx_cnt == rx_div) begin
                        rx_cnt <= 16'd0;
                        rx_div <= div_eff;
                        if (rx_bit == 3'd7) begin
                            rx_state <= S_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == rx_half) begin
                        rx_state <= S_IDLE;
                        rx_done  <= rx_s;
                        rx_bad   <= ~rx_s;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

endmodule
